osd_mam_burst_split: RTL

OSD_MAM_BURST_SPLIT -- requirements
Module: osd_mam_burst_split

---
 rtl/osd_mam_pkg.sv | 25 ++
 rtl/osd_mam_burst_split.sv | 124 ++++++++++++
 2 files changed

// File: rtl/osd_mam_pkg.sv
// Shared types and helpers for the MAM burst splitter.
package osd_mam_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DATA
    } state_e;

    // Sub-burst length: remaining words clipped to the burst cap and,
    // when enabled, to the words left before the next boundary.
    function automatic logic [13:0] sub_len(
        input logic [13:0] rem,
        input int          max_beats,
        input int          room,
        input bit          bound_en
    );
        int n;
        n = int'(rem);
        if (max_beats < n) n = max_beats;
        if (bound_en && room < n) n = room;
        return n[13:0];
    endfunction

endpackage

// File: rtl/osd_mam_burst_split.sv
// Splits upstream MAM bursts into capped, boundary-safe sub-bursts.
// Boundary clipping is enabled by OSD_MAM_BURST_SPLIT_BOUNDARY_EN.
module osd_mam_burst_split #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 32,
    parameter int MAX_BEATS  = 8,
    parameter int BOUNDARY   = 64
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    in_req_valid,
    output logic                    in_req_ready,
    input  logic                    in_req_rw,
    input  logic [ADDR_WIDTH-1:0]   in_req_addr,
    input  logic                    in_req_burst,
    input  logic [13:0]             in_req_beats,
    input  logic                    in_write_valid,
    output logic                    in_write_ready,
    input  logic [DATA_WIDTH-1:0]   in_write_data,
    input  logic [DATA_WIDTH/8-1:0] in_write_strb,
    output logic                    in_read_valid,
    input  logic                    in_read_ready,
    output logic [DATA_WIDTH-1:0]   in_read_data,
    output logic                    out_req_valid,
    input  logic                    out_req_ready,
    output logic                    out_req_rw,
    output logic                    out_req_burst,
    output logic [ADDR_WIDTH-1:0]   out_req_addr,
    output logic [13:0]             out_req_beats,
    output logic                    out_write_valid,
    input  logic                    out_write_ready,
    output logic [DATA_WIDTH-1:0]   out_write_data,
    output logic [DATA_WIDTH/8-1:0] out_write_strb,
    input  logic                    out_read_valid,
    output logic                    out_read_ready,
    input  logic [DATA_WIDTH-1:0]   out_read_data
);
    import osd_mam_pkg::*;

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int OFF_W = $clog2(BOUNDARY);
    localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(BYTES);
`ifdef OSD_MAM_BURST_SPLIT_BOUNDARY_EN
    localparam bit BOUND_EN = 1'b1;
`else
    localparam bit BOUND_EN = 1'b0;
`endif

    state_e                  state_q;
    logic                    rw_q;
    logic                    burst_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [13:0]             rem_q;
    logic [13:0]             cnt_q;
    logic [13:0]             sub_beats;
    logic                    in_data;
    logic                    beat;
    int                      room;

    always_comb begin
        room = (BOUNDARY - int'(addr_q[OFF_W-1:0])) / BYTES;
        sub_beats = 14'd1;
        if (burst_q)
            sub_beats = sub_len(rem_q, MAX_BEATS, room, BOUND_EN);
    end

    assign in_data = (state_q == DATA);

    assign in_req_ready  = (state_q == IDLE);
    assign out_req_valid = (state_q == ISSUE);
    assign out_req_rw    = rw_q;
    assign out_req_burst = burst_q;
    assign out_req_addr  = addr_q;
    assign out_req_beats = sub_beats;

    // Data channels only open in the direction of the active request.
    assign out_write_valid = in_data && rw_q && in_write_valid;
    assign in_write_ready  = in_data && rw_q && out_write_ready;
    assign out_write_data  = in_write_data;
    assign out_write_strb  = in_write_strb;
    assign in_read_valid   = in_data && !rw_q && out_read_valid;
    assign out_read_ready  = in_data && !rw_q && in_read_ready;
    assign in_read_data    = out_read_data;

    assign beat = (out_write_valid && out_write_ready)
               || (out_read_valid && out_read_ready);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            rw_q    <= 1'b0;
            burst_q <= 1'b0;
            addr_q  <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
        end else begin
            unique case (state_q)
                IDLE: if (in_req_valid) begin
                    rw_q    <= in_req_rw;
                    burst_q <= in_req_burst;
                    addr_q  <= in_req_addr;
                    if (!in_req_burst || in_req_beats == 14'd0)
                        rem_q <= 14'd1;
                    else
                        rem_q <= in_req_beats;
                    state_q <= ISSUE;
                end
                ISSUE: if (out_req_ready) begin
                    cnt_q   <= sub_beats;
                    state_q <= DATA;
                end
                DATA: if (beat) begin
                    rem_q  <= rem_q - 14'd1;
                    cnt_q  <= cnt_q - 14'd1;
                    addr_q <= addr_q + STEP;
                    if (cnt_q == 14'd1)
                        state_q <= (rem_q == 14'd1) ? IDLE : ISSUE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
